// File: rtl/local_bus_pkg.sv
// Shared definitions for the local-bus UART command receiver: framing
// constants, parser states and the CRC-8 byte update.
`default_nettype none

package local_bus_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'h55;
  localparam logic [7:0] CMD_IDENTIFY = 8'h3F;
  localparam logic [7:0] CRC8_POLY    = 8'h07;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    CRC  = 2'd3
  } parser_state_t;

  // MSB-first CRC-8, no reflection, no final XOR
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data_byte);
    logic [7:0] c;
    c = crc ^ data_byte;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 2-flop synchroniser, mid-bit sampling, 8N1 framing.
// Emits a one-cycle o_byte_valid, or o_frame_err when the stop bit is low.
`default_nettype none

module uart_byte_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err
);

  localparam logic [31:0] HALF_LAST = 32'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] FULL_LAST = 32'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t   r_state;
  logic [1:0]  r_sync;
  logic        r_prev;
  logic [31:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_valid;
  logic        r_err;
  logic [7:0]  r_byte;
  logic        w_rx;

  assign w_rx = r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RX_IDLE;
      r_sync    <= 2'b11;
      r_prev    <= 1'b1;
      r_cnt     <= 32'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_byte    <= 8'd0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_prev  <= w_rx;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= 32'd0;
          if (r_prev && !w_rx) r_state <= RX_START;
        end
        RX_START: begin
          // a line that is high again at mid start bit was only a glitch
          if (r_cnt == HALF_LAST) begin
            r_cnt     <= 32'd0;
            r_bit_idx <= 3'd0;
            r_state   <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt     <= 32'd0;
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt   <= 32'd0;
            r_state <= RX_IDLE;
            if (w_rx) begin
              r_valid <= 1'b1;
              r_byte  <= r_shift;
            end else begin
              r_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_byte_valid = r_valid;
  assign o_byte       = r_byte;
  assign o_frame_err  = r_err;

endmodule

`default_nettype wire

// File: rtl/local_bus_uart_cmd_rx.sv
// Local-bus command receiver: parses SYNC/CMD/[DATA x4]/CRC frames from the
// UART and issues CRC-checked write strobes, read requests and identify.
`default_nettype none

module local_bus_uart_cmd_rx
  import local_bus_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 50000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        lb_clk,
  input  logic        lb_reset_n,
  input  logic        rx,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        rd_req,
  output logic [3:0]  rd_addr,
  output logic        lb_crc_error_n,
  output logic        ubus_identify,
  output logic        rx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

  logic          w_byte_valid;
  logic [7:0]    w_byte;
  logic          w_frame_err;

  parser_state_t r_state;
  logic [7:0]    r_cmd;
  logic [7:0]    r_crc;
  logic [1:0]    r_cnt;
  logic [31:0]   r_shift;
  logic [31:0]   r_to_cnt;
  logic          r_wr_en;
  logic [3:0]    r_wr_addr;
  logic [31:0]   r_wr_data;
  logic          r_rd_req;
  logic [3:0]    r_rd_addr;
  logic          r_crc_ok;
  logic          r_ident;

  uart_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_rx (
    .clk          (lb_clk),
    .rst_n        (lb_reset_n),
    .i_rx         (rx),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_frame_err  (w_frame_err)
  );

  always_ff @(posedge lb_clk or negedge lb_reset_n) begin
    if (!lb_reset_n) begin
      r_state   <= IDLE;
      r_cmd     <= 8'd0;
      r_crc     <= 8'd0;
      r_cnt     <= 2'd0;
      r_shift   <= 32'd0;
      r_to_cnt  <= 32'd0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 4'd0;
      r_wr_data <= 32'd0;
      r_rd_req  <= 1'b0;
      r_rd_addr <= 4'd0;
      r_crc_ok  <= 1'b1;
      r_ident   <= 1'b0;
    end else begin
      r_wr_en  <= 1'b0;
      r_rd_req <= 1'b0;
      if (w_byte_valid || r_state == IDLE) r_to_cnt <= 32'd0;
      else                                 r_to_cnt <= r_to_cnt + 32'd1;

      if (w_frame_err) begin
        r_state <= IDLE;
      end else if (w_byte_valid) begin
        case (r_state)
          IDLE: begin
            if (w_byte == SYNC_BYTE) r_state <= CMD;
          end
          CMD: begin
            // 0x55 falls in the illegal range, so a repeated SYNC aborts
            if (w_byte[6:4] == 3'b000 || w_byte == CMD_IDENTIFY) begin
              r_cmd   <= w_byte;
              r_crc   <= crc8_byte(8'h00, w_byte);
              r_cnt   <= 2'd0;
              r_state <= w_byte[7] ? DATA : CRC;
            end else begin
              r_state <= IDLE;
            end
          end
          DATA: begin
            r_shift <= {r_shift[23:0], w_byte};
            r_crc   <= crc8_byte(r_crc, w_byte);
            r_cnt   <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) r_state <= CRC;
          end
          CRC: begin
            r_state <= IDLE;
            if (w_byte == r_crc) begin
              r_crc_ok <= 1'b1;
              if (r_cmd == CMD_IDENTIFY) begin
                r_ident <= 1'b1;
              end else if (r_cmd[7]) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_cmd[3:0];
                r_wr_data <= r_shift;
              end else begin
                r_rd_req  <= 1'b1;
                r_rd_addr <= r_cmd[3:0];
              end
            end else begin
              r_crc_ok <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_state != IDLE && r_to_cnt == TIMEOUT_LAST) begin
        r_state <= IDLE;
      end
    end
  end

  assign wr_en          = r_wr_en;
  assign wr_addr        = r_wr_addr;
  assign wr_data        = r_wr_data;
  assign rd_req         = r_rd_req;
  assign rd_addr        = r_rd_addr;
  assign lb_crc_error_n = r_crc_ok;
  assign ubus_identify  = r_ident;
  assign rx_busy        = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_local_bus_uart_cmd_rx.sv
// Scoreboard bench for local_bus_uart_cmd_rx at 10 clocks per UART bit.
`default_nettype none
`timescale 1ns/1ps

module tb_local_bus_uart_cmd_rx;

  localparam int CPB = 10;

  logic        lb_clk = 1'b0;
  logic        lb_reset_n = 1'b0;
  logic        rx = 1'b1;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_req;
  logic [3:0]  rd_addr;
  logic        lb_crc_error_n;
  logic        ubus_identify;
  logic        rx_busy;

  typedef struct {
    logic        is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] fb[7];

  local_bus_uart_cmd_rx #(
    .CLK_FREQ_HZ  (1000000),
    .BAUD         (100000),
    .TIMEOUT_BITS (20)
  ) dut (
    .lb_clk         (lb_clk),
    .lb_reset_n     (lb_reset_n),
    .rx             (rx),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .lb_crc_error_n (lb_crc_error_n),
    .ubus_identify  (ubus_identify),
    .rx_busy        (rx_busy)
  );

  always #500 lb_clk = ~lb_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // bit-serial reference: feed message bits MSB first into the register
  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    logic       fbk;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fbk = r[7] ^ b[i];
      r   = {r[6:0], 1'b0};
      if (fbk) r = r ^ 8'h07;
    end
    return r;
  endfunction

  always @(negedge lb_clk) begin
    if (lb_reset_n) begin
      if (wr_en && rd_req) begin
        tests++;
        fails++;
        $display("FAIL strobe_overlap: got wr_en=1 rd_req=1, expected at most one");
      end else if (wr_en || rd_req) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got wr_en=%0b rd_req=%0b, expected none", wr_en, rd_req);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("strobe_kind", {31'd0, wr_en}, {31'd0, e.is_wr});
          if (e.is_wr) begin
            check("wr_addr", {28'd0, wr_addr}, {28'd0, e.addr});
            check("wr_data", wr_data, e.data);
          end else begin
            check("rd_addr", {28'd0, rd_addr}, {28'd0, e.addr});
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge lb_clk) rx = 1'b0;
    repeat (CPB - 1) @(negedge lb_clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge lb_clk) rx = b[i];
      repeat (CPB - 1) @(negedge lb_clk);
    end
    @(negedge lb_clk) rx = stop_bit;
    repeat (CPB - 1) @(negedge lb_clk);
    @(negedge lb_clk) rx = 1'b1;
    if (!stop_bit) repeat (CPB) @(negedge lb_clk);
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) send_byte(fb[i], 1'b1);
    repeat (5) @(negedge lb_clk);
  endtask

  task automatic push(input logic is_wr, input logic [3:0] addr, input logic [31:0] data);
    exp_t e;
    e.is_wr = is_wr;
    e.addr  = addr;
    e.data  = data;
    q.push_back(e);
  endtask

  task automatic drained(input string name);
    check(name, q.size(), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_en"},   {31'd0, wr_en}, 32'd0);
    check({tag, "_wr_addr"}, {28'd0, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_rd_req"},  {31'd0, rd_req}, 32'd0);
    check({tag, "_rd_addr"}, {28'd0, rd_addr}, 32'd0);
    check({tag, "_crc_n"},   {31'd0, lb_crc_error_n}, 32'd1);
    check({tag, "_ident"},   {31'd0, ubus_identify}, 32'd0);
    check({tag, "_busy"},    {31'd0, rx_busy}, 32'd0);
  endtask

  task automatic random_write(input logic [3:0] addr, input logic [31:0] data);
    logic [7:0] c;
    fb[0] = 8'h55;
    fb[1] = {4'h8, addr};
    fb[2] = data[31:24];
    fb[3] = data[23:16];
    fb[4] = data[15:8];
    fb[5] = data[7:0];
    c = 8'h00;
    for (int i = 1; i < 6; i++) c = crc_ref(c, fb[i]);
    fb[6] = c;
    push(1'b1, addr, data);
    send_frame(7);
  endtask

  initial begin
    repeat (3) @(negedge lb_clk);
    check_reset_values("reset");
    lb_reset_n = 1'b1;
    repeat (5) @(negedge lb_clk);

    // hand-computed write frame
    fb = '{8'h55, 8'h85, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7A};
    push(1'b1, 4'd5, 32'h0);
    send_frame(7);
    drained("write_zero");
    check("write_zero_crc_n", {31'd0, lb_crc_error_n}, 32'd1);

    for (int k = 0; k < 3; k++) begin
      random_write(4'($urandom_range(0, 15)), $urandom);
      drained("write_rand");
    end

    fb = '{8'h55, 8'h03, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00};
    push(1'b0, 4'd3, 32'h0);
    send_frame(3);
    drained("read");

    // bad CRC, then the same frame with a good CRC
    fb = '{8'h55, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(3);
    check("bad_crc_n", {31'd0, lb_crc_error_n}, 32'd0);
    fb = '{8'h55, 8'h03, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00};
    push(1'b0, 4'd3, 32'h0);
    send_frame(3);
    drained("good_after_bad");
    check("good_after_bad_crc_n", {31'd0, lb_crc_error_n}, 32'd1);

    fb = '{8'h55, 8'h3F, 8'hBD, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(3);
    check("identify", {31'd0, ubus_identify}, 32'd1);
    fb = '{8'h55, 8'h03, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00};
    push(1'b0, 4'd3, 32'h0);
    send_frame(3);
    drained("read_after_ident");
    check("identify_sticky", {31'd0, ubus_identify}, 32'd1);

    // inter-byte timeout inside DATA
    fb = '{8'h55, 8'h85, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(3);
    check("busy_mid_frame", {31'd0, rx_busy}, 32'd1);
    repeat (200 * CPB) @(negedge lb_clk);
    check("busy_after_timeout", {31'd0, rx_busy}, 32'd0);
    drained("timeout_no_strobe");
    random_write(4'd5, 32'hDEADBEEF);
    drained("write_after_timeout");

    // stop bit low mid-frame
    fb = '{8'h55, 8'h85, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(2);
    check("busy_before_frame_err", {31'd0, rx_busy}, 32'd1);
    send_byte(8'h12, 1'b0);
    check("busy_after_frame_err", {31'd0, rx_busy}, 32'd0);
    drained("frame_err_no_strobe");

    // async reset in DATA with non-reset output state beforehand
    fb = '{8'h55, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(3);
    check("pre_reset_crc_n", {31'd0, lb_crc_error_n}, 32'd0);
    fb = '{8'h55, 8'h85, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
    send_frame(4);
    check("busy_in_data", {31'd0, rx_busy}, 32'd1);
    @(negedge lb_clk);
    #100 lb_reset_n = 1'b0;
    #1 check_reset_values("async_rst");
    repeat (3) @(negedge lb_clk);
    lb_reset_n = 1'b1;
    repeat (20) @(negedge lb_clk);
    fb = '{8'h55, 8'h03, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00};
    push(1'b0, 4'd3, 32'h0);
    send_frame(3);
    drained("read_after_reset");
    check("ident_after_reset", {31'd0, ubus_identify}, 32'd0);

    repeat (20) @(negedge lb_clk);
    drained("final_queue");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
